fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter, drives the memory byte address, and captures the returned 32-bit big-endian instruction word into an IF/ID pipeline register.
- Hands the word downstream to decode with a valid/ready handshake; supports stall, branch redirect/flush and a fetch enable.

Parameters:
- WORD_LEN, 32, width of PC, address and instruction (from defines).
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- fetch_en  in  1  1 = fetch permitted; 0 = no new fetches issued.
- redirect  in  1  branch/jump taken; flush and load new PC.
- redirect_pc  in  WORD_LEN  redirect target address.
- imem_addr  out  WORD_LEN  byte address to instruction memory (= pc).
- imem_instruction  in  WORD_LEN  word returned combinationally for imem_addr.
- id_valid  out  1  IF/ID register holds a valid instruction.
- id_ready  in  1  decode accepts the word this cycle.
- id_instr  out  WORD_LEN  captured instruction.
- id_pc  out  WORD_LEN  address the captured instruction was fetched from.
- fetch_count  out  WORD_LEN  fetched-instruction counter (see Optional Feature).

Behaviour:
- Reset (rstn low, asynchronous, immediate):
  - pc = RESET_PC, id_valid = 0, id_instr = 0, id_pc = 0, fetch_count = 0.
  - imem_addr follows pc, so it is RESET_PC during reset.
- imem_addr = pc, combinational. Memory read is combinational; fetch latency = 1 cycle from pc to id_instr.
- Internal "advance" = !id_valid || id_ready.
- Per rising edge, priority order:
  1. redirect=1:
     - pc <= {redirect_pc[WORD_LEN-1:2], 2'b00} (target force-aligned).
     - id_valid <= 0. The instruction in flight is discarded even if id_ready=1 this cycle; it counts as consumed-and-squashed.
     - No fetch this cycle.
  2. Else if !advance (stall): pc, id_valid, id_instr, id_pc all hold.
  3. Else if fetch_en=1:
     - id_instr <= imem_instruction, id_pc <= pc, id_valid <= 1.
     - pc <= pc + PC_STEP, modulo 2^WORD_LEN (0xFFFFFFFC wraps to 0x00000000).
  4. Else (fetch_en=0, advance): id_valid <= 0; pc holds.
- Handshake:
  - A word transfers when id_valid && id_ready.
  - id_instr and id_pc must not change while id_valid=1 and id_ready=0.
- Throughput: one instruction per cycle when fetch_en=1 and id_ready=1.
- First valid word appears after the first rising edge following rstn release with fetch_en=1; id_pc = RESET_PC.
- redirect together with a stall: redirect wins.
- redirect together with fetch_en=0: pc still loads.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: fetch_count increments by 1 on every cycle that executes rule 3 (new word captured). Wraps at 2^WORD_LEN. Cleared by reset. Squashed words remain counted.
- Undefined: fetch_count is tied to 0 and no counter register is synthesised.

Test Plan:
- Reset then fetch_en=1, id_ready=1, memory at 0 = 0x80A00007, at 4 = 0x04011800 -> cycle1 id_pc=0 id_instr=0x80A00007; cycle2 id_pc=4 id_instr=0x04011800; imem_addr=8.
- Stall: id_ready=0 while id_pc=4 for 3 cycles -> id_instr, id_pc, imem_addr=8 held; id_ready=1 -> next word from addr 8.
- Redirect to 0x00000013 while id_ready=0 and id_valid=1 -> next edge id_valid=0, imem_addr=0x10; following edge id_pc=0x10.
- Wrap: redirect to 0xFFFFFFFC -> fetch at 0xFFFFFFFC, then imem_addr=0x00000000.
- fetch_en=0 with id_ready=1 -> id_valid drops after one edge, pc holds. rstn pulsed low mid-stream -> outputs cleared immediately, before next edge.
- With FETCH_PERF_CNT_EN, 5 fetches plus 1 redirect -> fetch_count=5. Without it -> fetch_count=0 throughout.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC, drives a combinational instruction memory and hands captured
// words to decode over a valid/ready handshake with stall, redirect and enable.
// Optional fetch counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int unsigned         WORD_LEN = 32,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0,
    parameter int unsigned         PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                fetch_en,
    input  logic                redirect,
    input  logic [WORD_LEN-1:0] redirect_pc,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic [WORD_LEN-1:0] imem_instruction,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [WORD_LEN-1:0] id_instr,
    output logic [WORD_LEN-1:0] id_pc,
    output logic [WORD_LEN-1:0] fetch_count
);

    logic [WORD_LEN-1:0] pc_d, pc_q;
    logic [WORD_LEN-1:0] id_instr_d, id_instr_q;
    logic [WORD_LEN-1:0] id_pc_d, id_pc_q;
    logic                id_valid_d, id_valid_q;
    logic                advance;

    // IF/ID register may take a new word when empty or being consumed.
    assign advance = !id_valid_q || id_ready;

    // Next-state: redirect > stall > fetch > idle (drain).
    always_comb begin
        pc_d       = pc_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        if (redirect) begin
            // Target forced word-aligned; the in-flight word is squashed.
            pc_d       = {redirect_pc[WORD_LEN-1:2], 2'b00};
            id_valid_d = 1'b0;
        end else if (!advance) begin
            // Stall: everything holds so decode sees a stable word.
        end else if (fetch_en) begin
            id_instr_d = imem_instruction;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
            pc_d       = pc_q + WORD_LEN'(PC_STEP);
        end else begin
            id_valid_d = 1'b0;
        end
    end

    // PC and IF/ID pipeline register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q       <= RESET_PC;
            id_instr_q <= '0;
            id_pc_q    <= '0;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [WORD_LEN-1:0] fetch_count_d, fetch_count_q;
    logic                fetch_now;

    // Counts captures, including words later squashed by a redirect.
    assign fetch_now = !redirect && advance && fetch_en;

    // Counter next-state; wraps naturally.
    always_comb begin
        fetch_count_d = fetch_count_q;
        if (fetch_now) begin
            fetch_count_d = fetch_count_q + WORD_LEN'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. A reference model predicts
// each edge; captured words are queued and compared when decode consumes them.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_cnt;
    logic [63:0] sb_q[$];   // {pc, instr}

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk              (clk),
        .rstn             (rstn),
        .fetch_en         (fetch_en),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .imem_addr        (imem_addr),
        .imem_instruction (imem_instruction),
        .id_valid         (id_valid),
        .id_ready         (id_ready),
        .id_instr         (id_instr),
        .id_pc            (id_pc),
        .fetch_count      (fetch_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h80A0_0007;
            32'h0000_0004: return 32'h0401_1800;
            default:       return a ^ 32'hDEAD_BEEF;
        endcase
    endfunction

    assign imem_instruction = mem_word(imem_addr);

    function automatic logic [31:0] exp_cnt();
`ifdef FETCH_PERF_CNT_EN
        return m_cnt;
`else
        return 32'h0;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_cnt   = 32'h0;
        sb_q.delete();
    endtask

    // One clock: check pre-edge outputs, predict the edge, check post-edge.
    task automatic cycle();
        logic [63:0] e;
        #1;
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
        if (m_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_empty", 32'h1, 32'h0);
            end else begin
                e = sb_q[0];
                check_eq("id_pc", id_pc, e[63:32]);
                check_eq("id_instr", id_instr, e[31:0]);
                if (id_ready) void'(sb_q.pop_front());
            end
        end
        if (redirect) begin
            m_pc    = {redirect_pc[31:2], 2'b00};
            m_valid = 1'b0;
            sb_q.delete();
        end else if (m_valid && !id_ready) begin
            // stall
        end else if (fetch_en) begin
            sb_q.push_back({m_pc, mem_word(m_pc)});
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_cnt   = m_cnt + 32'd1;
        end else begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_eq("fetch_count", fetch_count, exp_cnt());
    endtask

    initial begin
        rstn        = 1'b0;
        fetch_en    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b0;
        model_reset();
        #3;
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_valid", {31'b0, id_valid}, 32'h0);
        check_eq("rst_instr", id_instr, 32'h0);
        check_eq("rst_pc", id_pc, 32'h0);
        check_eq("rst_cnt", fetch_count, 32'h0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Sequential fetch at full throughput.
        fetch_en = 1'b1;
        id_ready = 1'b1;
        cycle();
        check_eq("first_pc", id_pc, 32'h0);
        check_eq("first_instr", id_instr, 32'h80A0_0007);
        cycle();
        check_eq("second_pc", id_pc, 32'h4);
        check_eq("second_instr", id_instr, 32'h0401_1800);
        check_eq("second_addr", imem_addr, 32'h8);

        // Stall for three cycles, then resume.
        id_ready = 1'b0;
        repeat (3) cycle();
        check_eq("stall_pc", id_pc, 32'h4);
        check_eq("stall_addr", imem_addr, 32'h8);
        id_ready = 1'b1;
        cycle();
        check_eq("resume_pc", id_pc, 32'h8);

        // Redirect while stalled with a valid word: redirect wins.
        id_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0013;
        cycle();
        redirect = 1'b0;
        check_eq("redir_valid", {31'b0, id_valid}, 32'h0);
        check_eq("redir_addr", imem_addr, 32'h10);
        id_ready = 1'b1;
        cycle();
        check_eq("redir_pc", id_pc, 32'h10);

        // Redirect while the word is being consumed squashes it.
        cycle();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        cycle();
        check_eq("wrap_pc", id_pc, 32'hFFFF_FFFC);
        check_eq("wrap_addr", imem_addr, 32'h0);
        cycle();

        // Fetch disabled: drain, pc holds.
        fetch_en = 1'b0;
        cycle();
        check_eq("dis_valid", {31'b0, id_valid}, 32'h0);
        check_eq("dis_addr", imem_addr, 32'h4);
        cycle();

        // Random mix of ready / enable.
        for (int i = 0; i < 40; i++) begin
            fetch_en = 1'($urandom_range(0, 3) != 0);
            id_ready = 1'($urandom_range(0, 2) != 0);
            cycle();
        end

        // Asynchronous reset mid-stream.
        fetch_en = 1'b1;
        id_ready = 1'b1;
        repeat (2) cycle();
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_eq("mrst_valid", {31'b0, id_valid}, 32'h0);
        check_eq("mrst_addr", imem_addr, 32'h0);
        check_eq("mrst_instr", id_instr, 32'h0);
        check_eq("mrst_pc", id_pc, 32'h0);
        check_eq("mrst_cnt", fetch_count, 32'h0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Five fetches then a redirect with fetch disabled.
        repeat (5) cycle();
        fetch_en    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        cycle();
        redirect = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_cnt", fetch_count, 32'd5);
`else
        check_eq("perf_cnt", fetch_count, 32'd0);
`endif
        check_eq("perf_addr", imem_addr, 32'h100);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
